// File: rtl/cordic_pkg.sv
// cordic_pkg: shared angle type, arctangent table, quadrant angles, FSM states and gain shifts for the CORDIC blocks
package cordic_pkg;
    localparam int ANGLE_W = 16;
    typedef logic signed [ANGLE_W-1:0] angle_t;
    localparam angle_t ATAN_DEG_Q7 [16] = '{
        16'sd5760, 16'sd3400, 16'sd1797, 16'sd912, 16'sd458, 16'sd229, 16'sd115, 16'sd57,
        16'sd29, 16'sd14, 16'sd7, 16'sd4, 16'sd2, 16'sd1, 16'sd0, 16'sd0
    };
    localparam angle_t ANG_P90 = 16'sd11520;
    localparam angle_t ANG_N90 = -16'sd11520;
    localparam angle_t ANG_180 = 16'sd23040;
    typedef enum logic [2:0] {IDLE, PRE, ITER, GAIN, DONE} state_t;
    // K ~= 2^-1 + 2^-3 - 2^-6 - 2^-9 - 2^-13
    localparam int GAIN_SH [5] = '{1, 3, 6, 9, 13};
endpackage

// File: rtl/cordic_vec_stage.sv
// cordic_vec_stage: one combinational vectoring micro-rotation that steers y toward zero
module cordic_vec_stage #(
    parameter int XW = 18,
    parameter int AW = 16
) (
    input  logic signed [XW-1:0] x,
    input  logic signed [XW-1:0] y,
    input  logic signed [AW-1:0] z,
    input  logic [4:0]           i,
    input  logic signed [AW-1:0] atan_i,
    output logic signed [XW-1:0] x_n,
    output logic signed [XW-1:0] y_n,
    output logic signed [AW-1:0] z_n
);
    logic neg;
    always_comb begin
        neg = y[XW-1];
        x_n = neg ? x - (y >>> i) : x + (y >>> i);
        y_n = neg ? y + (x >>> i) : y - (x >>> i);
        z_n = neg ? z - atan_i : z + atan_i;
    end
endmodule

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative CORDIC vectoring engine returning atan2(y,x) in Q9.7 degrees and magnitude.
// Define CORDIC_GAIN_COMP_EN to scale the magnitude by K in an extra GAIN cycle.
module cordic_vectoring
    import cordic_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int ITERATIONS = 16,
    parameter int ANG_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x_in,
    input  logic [WIDTH-1:0] y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ANG_W-1:0] angle_out,
    output logic [WIDTH+1:0] mag_out
);
    localparam int XW = WIDTH + 2;
    localparam int CW = $clog2(ITERATIONS);
`ifdef CORDIC_GAIN_COMP_EN
    localparam state_t AFTER_ITER = GAIN;
`else
    localparam state_t AFTER_ITER = DONE;
`endif
    state_t state, state_n;
    logic signed [XW-1:0] x, y, xs, ys, fx;
    logic signed [ANG_W-1:0] z, zs, fz, atan_i, a180, ang;
    logic [CW-1:0] i;
    logic zero, last, fin;

    assign atan_i = ANG_W'(ATAN_DEG_Q7[4'(i)]);
    assign last   = i == CW'(ITERATIONS - 1);
    assign a180   = ANG_W'(ANG_180);

    cordic_vec_stage #(.XW(XW), .AW(ANG_W)) u_stage (
        .x(x), .y(y), .z(z), .i(5'(i)), .atan_i(atan_i),
        .x_n(xs), .y_n(ys), .z_n(zs)
    );

`ifdef CORDIC_GAIN_COMP_EN
    assign fx  = (x >>> GAIN_SH[0]) + (x >>> GAIN_SH[1]) - (x >>> GAIN_SH[2])
               - (x >>> GAIN_SH[3]) - (x >>> GAIN_SH[4]);
    assign fz  = z;
    assign fin = state == GAIN;
`else
    assign fx  = xs;
    assign fz  = zs;
    assign fin = state == ITER && last;
`endif
    // fold -180 (and any overshoot below it) onto the positive side
    assign ang = fz <= -a180 ? fz + a180 + a180 : fz;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n   = state;
        in_ready  = state == IDLE;
        out_valid = state == DONE;
        case (state)
            IDLE:    state_n = in_valid ? PRE : IDLE;
            PRE:     state_n = ITER;
            ITER:    state_n = last ? AFTER_ITER : ITER;
            GAIN:    state_n = DONE;
            DONE:    state_n = out_ready ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            x         <= '0;
            y         <= '0;
            z         <= '0;
            i         <= '0;
            zero      <= 1'b0;
            angle_out <= '0;
            mag_out   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    x <= XW'($signed(x_in));
                    y <= XW'($signed(y_in));
                    i <= '0;
                end
                PRE: begin
                    x    <= x[XW-1] ? (y[XW-1] ? -y : y) : x;
                    y    <= x[XW-1] ? (y[XW-1] ? x : -x) : y;
                    z    <= x[XW-1] ? (y[XW-1] ? ANG_W'(ANG_N90) : ANG_W'(ANG_P90)) : '0;
                    zero <= x == '0 && y == '0;
                end
                ITER: begin
                    x <= xs;
                    y <= ys;
                    z <= zs;
                    i <= i + 1'b1;
                end
                default: ;
            endcase
            if (fin) begin
                angle_out <= zero ? '0 : ang;
                mag_out   <= zero ? '0 : fx;
            end
        end
endmodule

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: scoreboard bench checking atan2/magnitude/latency against a real-arithmetic model
module tb_cordic_vectoring;
    localparam int ITERATIONS = 16;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int  LAT    = ITERATIONS + 3;
    localparam real GAIN_K = 1.0;
`else
    localparam int  LAT    = ITERATIONS + 2;
    localparam real GAIN_K = 1.6467602581;
`endif
    localparam real PI = 3.14159265358979;

    logic clk = 0, rst_n = 1, in_valid = 0, out_ready = 1;
    logic [15:0] x_in = '0, y_in = '0;
    logic in_ready, out_valid;
    logic [15:0] angle_out;
    logic [17:0] mag_out;

    cordic_vectoring dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .out_valid(out_valid), .out_ready(out_ready),
        .angle_out(angle_out), .mag_out(mag_out)
    );

    always #5 clk = ~clk;

    typedef struct {int ang; int mag; int atol; int mtol; int hs;} exp_t;
    exp_t q[$];
    int n_chk = 0, n_fail = 0, ncyc = 0, atol_cur = 8;
    logic ov_prev = 0;

    task automatic chk(input string name, input longint act, input longint exp, input longint tol);
        n_chk++;
        if (act > exp + tol || act < exp - tol) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (+/-%0d)", name, act, exp, tol);
        end
    endtask

    function automatic int wrap(input int d);
        return ((d % 46080) + 46080 + 23040) % 46080 - 23040;
    endfunction

    // magnitude slack covers shift-truncation drift on small vectors and the approximate K
    function automatic exp_t model(input int xv, input int yv, input int hs, input int atol);
        exp_t e;
        real a;
        e.hs = hs;
        if (xv == 0 && yv == 0) begin
            e.ang = 0; e.mag = 0; e.atol = 0; e.mtol = 0;
        end else begin
            a = $atan2(real'(yv), real'(xv)) * 180.0 / PI * 128.0;
            e.ang = int'(a);
            if (e.ang <= -23040) e.ang += 46080;
            e.mag  = int'($sqrt(real'(xv) * xv + real'(yv) * yv) * GAIN_K);
            e.atol = atol;
            e.mtol = 16 + e.mag / 1024;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        int a, d;
        ncyc++;
        if (in_valid && in_ready)
            q.push_back(model(int'($signed(x_in)), int'($signed(y_in)), ncyc, atol_cur));
        if (out_valid && !ov_prev) begin
            if (q.size() == 0) chk("unexpected_output", 1, 0, 0);
            else chk("latency", ncyc - q[0].hs, LAT, 0);
        end
        if (out_valid && out_ready && q.size() > 0) begin
            e = q.pop_front();
            a = int'($signed(angle_out));
            d = wrap(a - e.ang);
            n_chk++;
            if (d > e.atol || d < -e.atol) begin
                n_fail++;
                $display("FAIL angle: got %0d, want %0d (+/-%0d)", a, e.ang, e.atol);
            end
            chk("angle_range", a > -23040, 1, 0);
            chk("mag", mag_out, e.mag, e.mtol);
        end
        ov_prev = out_valid;
    end

    task automatic send(input int xv, input int yv);
        int n = 0;
        @(posedge clk); #1;
        in_valid = 1; x_in = 16'(xv); y_in = 16'(yv);
        @(negedge clk);
        while (!in_ready && n < 200) begin @(negedge clk); n++; end
        if (n >= 200) chk("in_ready_timeout", 0, 1, 0);
        @(posedge clk); #1;
        in_valid = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() > 0 && n < 300) begin @(negedge clk); n++; end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0, 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int xv, yv, n;
        logic [15:0] rx, ry, held_a;
        logic [17:0] held_m;
        #1 rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1, 0);
        chk("rst_out_valid", out_valid, 0, 0);
        chk("rst_angle", angle_out, 0, 0);
        chk("rst_mag", mag_out, 0, 0);
        @(negedge clk) rst_n = 1;

        send(100, 0);
        send(0, 1000);
        send(-1000, -1000);
        send(-1000, 0);
        send(0, 0);
        send(-32768, -32768);
        send(32767, -32768);
        drain();

        atol_cur = 12;
        for (int k = 0; k < 20; k++) begin
            do begin
                rx = 16'($urandom); ry = 16'($urandom);
                xv = int'($signed(rx)); yv = int'($signed(ry));
            end while (xv * xv + yv * yv < 4096 * 4096);
            send(xv, yv);
        end
        drain();

        atol_cur = 8;
        @(posedge clk); #1;
        out_ready = 0; in_valid = 1; x_in = 16'sd3000; y_in = -16'sd4000;
        @(negedge clk);
        @(posedge clk); #1;
        x_in = -16'sd2000; y_in = 16'sd500;
        n = 0;
        while (!out_valid && n < 100) begin @(negedge clk); n++; end
        chk("hold_out_valid_seen", out_valid, 1, 0);
        held_a = angle_out; held_m = mag_out;
        repeat (10) begin
            @(negedge clk);
            chk("hold_in_ready", in_ready, 0, 0);
            chk("hold_out_valid", out_valid, 1, 0);
            chk("hold_angle", angle_out, held_a, 0);
            chk("hold_mag", mag_out, held_m, 0);
            chk("hold_captures", q.size(), 1, 0);
        end
        @(posedge clk); #1;
        out_ready = 1;
        @(negedge clk);
        @(negedge clk);
        chk("release_out_valid", out_valid, 0, 0);
        chk("release_in_ready", in_ready, 1, 0);
        @(posedge clk); #1;
        in_valid = 0;
        drain();

        send(1000, 500);
        repeat (4) @(negedge clk);
        #1 rst_n = 0;
        #1;
        chk("async_rst_in_ready", in_ready, 1, 0);
        chk("async_rst_out_valid", out_valid, 0, 0);
        chk("async_rst_angle", angle_out, 0, 0);
        chk("async_rst_mag", mag_out, 0, 0);
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1;
        send(100, 100);
        drain();

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
